// File: rtl/encoder_2_bit.sv
// encoder_2_bit: 4-input priority encoder with registered index, valid and
// multi-request flags. Priority direction is chosen by PRIORITY_MSB
// (1 = highest set index wins, 0 = lowest set index wins). The outputs
// load on a rising clk edge when en=1, hold when en=0, and clear
// asynchronously while rst_n is low.
module encoder_2_bit #(
  parameter bit PRIORITY_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i,
  input  logic       en,
  output logic [1:0] o,
  output logic       valid,
  output logic       multi
);

  // blocked[k] is set when a request with higher priority than k is present;
  // win is then the one-hot winning request (all zero when i is zero).
  logic [3:0] blocked;
  logic [3:0] win;

  logic [1:0] o_next;
  logic       valid_next;
  logic       multi_next;
  logic [2:0] req_count;

  logic [1:0] o_reg;
  logic       valid_reg;
  logic       multi_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_prio
      if (PRIORITY_MSB) begin : g_msb
        // Any request above this index takes priority.
        if (gi == 3) begin : g_top
          assign blocked[gi] = 1'b0;
        end else begin : g_rest
          assign blocked[gi] = |i[3:gi+1];
        end
      end else begin : g_lsb
        // Any request below this index takes priority.
        if (gi == 0) begin : g_bottom
          assign blocked[gi] = 1'b0;
        end else begin : g_rest
          assign blocked[gi] = |i[gi-1:0];
        end
      end
      assign win[gi] = i[gi] & ~blocked[gi];
    end
  endgenerate

  // Next-state values: binary index of the winner, any-request and
  // two-or-more-request flags. An all-zero request vector yields 00/0/0.
  always_comb begin
    req_count  = 3'd0;
    for (int k = 0; k < 4; k++) begin
      req_count = req_count + {2'b00, i[k]};
    end
    o_next     = {win[3] | win[2], win[3] | win[1]};
    valid_next = |i;
    multi_next = (req_count >= 3'd2);
  end

  // Output registers: capture on en, hold otherwise, clear on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_reg     <= 2'b00;
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
    end else if (en) begin
      o_reg     <= o_next;
      valid_reg <= valid_next;
      multi_reg <= multi_next;
    end
  end

  assign o     = o_reg;
  assign valid = valid_reg;
  assign multi = multi_reg;

endmodule

// File: tb/tb_encoder_2_bit.sv
// Bench for encoder_2_bit: one instance per priority setting, shared stimulus,
// directed vectors followed by randomized traffic with occasional async resets.
module tb_encoder_2_bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] i;
  logic       en;

  logic [1:0] o_msb, o_lsb;
  logic       valid_msb, valid_lsb;
  logic       multi_msb, multi_lsb;

  int checks   = 0;
  int failures = 0;

  // Expected registered state per instance, packed {o, valid, multi}.
  logic [3:0] exp_msb;
  logic [3:0] exp_lsb;

  encoder_2_bit #(.PRIORITY_MSB(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .i(i), .en(en),
    .o(o_msb), .valid(valid_msb), .multi(multi_msb)
  );

  encoder_2_bit #(.PRIORITY_MSB(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .i(i), .en(en),
    .o(o_lsb), .valid(valid_lsb), .multi(multi_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {o,valid,multi}=%b expected %b", tag, act, exp);
    end
  endtask

  // Reference: scan the request vector in priority order, popcount for multi.
  function automatic logic [3:0] model(input logic [3:0] v, input bit msb);
    int  idx   = 0;
    bit  found = 0;
    for (int n = 0; n < 4; n++) begin
      int k = msb ? 3 - n : n;
      if (v[k] && !found) begin
        idx   = k;
        found = 1;
      end
    end
    return {2'(idx), (v != 4'b0), ($countones(v) >= 2)};
  endfunction

  task automatic check_both(input string tag);
    check({tag, "_msb"}, {o_msb, valid_msb, multi_msb}, exp_msb);
    check({tag, "_lsb"}, {o_lsb, valid_lsb, multi_lsb}, exp_lsb);
  endtask

  // Drive one cycle of stimulus, then check one edge later.
  task automatic apply(input string tag, input logic [3:0] vec, input logic e);
    @(negedge clk);
    i  = vec;
    en = e;
    check({tag, "_x_on_i"}, {3'b000, (en === 1'b1) && $isunknown(i)}, 4'b0000);
    if (rst_n && e) begin
      exp_msb = model(vec, 1'b1);
      exp_lsb = model(vec, 1'b0);
    end
    @(posedge clk);
    #1;
    check_both(tag);
    $display("txn %-10s i=%b en=%b msb{o,v,m}=%b lsb{o,v,m}=%b", tag, vec, e,
             {o_msb, valid_msb, multi_msb}, {o_lsb, valid_lsb, multi_lsb});
  endtask

  // Pulse rst_n low between edges and check the clear happens before the edge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    en = 1'b0;
    #1;
    rst_n   = 1'b0;
    exp_msb = 4'b0000;
    exp_lsb = 4'b0000;
    #1;
    check_both(tag);
    $display("txn %-10s async reset pulse", tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sweep_vec;
    rst_n   = 1'b0;
    i       = 4'b1111;
    en      = 1'b1;
    exp_msb = 4'b0000;
    exp_lsb = 4'b0000;

    // Held in reset with active requests: outputs stay clear.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_both("in_reset");
      $display("txn %-10s cycle=%0d", "in_reset", c);
    end
    @(negedge clk);
    rst_n = 1'b1;

    apply("post_rst", 4'b1111, 1'b1);

    // Directed vectors.
    apply("v0101", 4'b0101, 1'b1);
    apply("v1000", 4'b1000, 1'b1);
    apply("v1010", 4'b1010, 1'b1);
    apply("v1100", 4'b1100, 1'b1);

    // One-hot sweep then zero.
    for (int k = 0; k < 4; k++) begin
      sweep_vec = 4'b0001 << k;
      apply("onehot", sweep_vec, 1'b1);
    end
    apply("zero", 4'b0000, 1'b1);

    // Hold while en=0.
    apply("cap0100", 4'b0100, 1'b1);
    for (int c = 0; c < 3; c++) apply("hold", 4'b1111, 1'b0);

    // Async reset mid-operation with valid=1.
    apply("pre_rst", 4'b1111, 1'b1);
    reset_pulse("async_rst");
    apply("after_rst", 4'b0011, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) reset_pulse("rand_rst");
      apply("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
